// File: rtl/lsu_byte_initiator_pkg.sv
// rtl/lsu_byte_initiator_pkg.sv - access size codes, LSU state type and beat-count helper
package lsu_byte_initiator_pkg;

    localparam logic [2:0] LB_SB = 3'b000;
    localparam logic [2:0] LH_SH = 3'b001;
    localparam logic [2:0] LW_SW = 3'b010;
    localparam logic [2:0] LBU   = 3'b100;
    localparam logic [2:0] LHU   = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R,
        RESP
    } lsu_state_t;

    // Unsigned codes on a store still move the same number of bytes as their signed twin.
    function automatic logic [2:0] beat_count(input logic [2:0] size, input logic we);
        logic [2:0] n;
        case (size)
            LW_SW:      n = 3'd4;
            LH_SH, LHU: n = 3'd2;
            default:    n = 3'd1;
        endcase
        if (we && size == LBU) begin
            n = 3'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// rtl/lsu_load_extend.sv - sign/zero extension of reassembled little-endian load bytes
import lsu_byte_initiator_pkg::*;

module lsu_load_extend (
    input  logic [31:0] load_bytes,
    input  logic [2:0]  size,
    output logic [31:0] load_data
);

    always_comb begin
        load_data = {{24{load_bytes[7]}}, load_bytes[7:0]};
        case (size)
            LBU:     load_data = {24'h000000, load_bytes[7:0]};
            LH_SH:   load_data = {{16{load_bytes[15]}}, load_bytes[15:0]};
            LHU:     load_data = {16'h0000, load_bytes[15:0]};
            LW_SW:   load_data = load_bytes;
            default: load_data = {{24{load_bytes[7]}}, load_bytes[7:0]};
        endcase
    end

endmodule

// File: rtl/lsu_byte_initiator.sv
// rtl/lsu_byte_initiator.sv - serialises core load/store requests into single-byte memory beats
import lsu_byte_initiator_pkg::*;

module lsu_byte_initiator #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [7:0]  mem_rdata
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    lsu_state_t      state;
    logic            we_q;
    logic [2:0]      size_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     buf_q;
    logic [1:0]      k;
    logic [1:0]      last_k;
    logic [WW-1:0]   wait_cnt;
    logic            err_q;
    logic [31:0]     ext_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            size_q   <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            buf_q    <= 32'h0;
            k        <= 2'd0;
            last_k   <= 2'd0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        size_q   <= req_size;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        last_k   <= 2'(beat_count(req_size, req_we) - 3'd1);
                        k        <= 2'd0;
                        buf_q    <= 32'h0;
                        err_q    <= 1'b0;
                        wait_cnt <= '0;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        if (we_q) begin
                            if (k == last_k) begin
                                state <= RESP;
                            end else begin
                                k <= k + 2'd1;
                            end
                        end else begin
                            wait_cnt <= '0;
                            state    <= WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    // rvalid is tested first so a byte landing on the last wait cycle still counts.
                    if (mem_rvalid) begin
                        buf_q[{k, 3'b000} +: 8] <= mem_rdata;
                        if (k == last_k) begin
                            state <= RESP;
                        end else begin
                            k     <= k + 2'd1;
                            state <= REQ;
                        end
                    end else if (wait_cnt == WW'(MAX_WAIT - 1)) begin
                        err_q <= 1'b1;
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    lsu_load_extend u_extend (
        .load_bytes (buf_q),
        .size       (size_q),
        .load_data  (ext_data)
    );

    // Beat and response fields are forced to zero whenever they are not qualified.
    assign req_ready  = (state == IDLE);
    assign mem_req    = (state == REQ);
    assign mem_we     = mem_req & we_q;
    assign mem_addr   = mem_req ? (addr_q + {30'h0, k}) : 32'h0;
    assign mem_wdata  = mem_req ? wdata_q[{k, 3'b000} +: 8] : 8'h00;
    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = (resp_valid && !we_q && !err_q) ? ext_data : 32'h0;

endmodule

// File: tb/tb_lsu_byte_initiator.sv
// tb/tb_lsu_byte_initiator.sv - randomized self-checking bench with a byte-memory responder model
import lsu_byte_initiator_pkg::*;

module tb_lsu_byte_initiator;

    localparam int MW = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_size = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    int gnt_stall = 0;
    int rv_delay = 0;
    bit rv_enable = 1'b1;
    bit stray_rvalid = 1'b0;

    bit          pending = 1'b0;
    int          rv_cnt = 0;
    int          stall_cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    logic [31:0] held_addr = 32'h0;
    logic [7:0]  held_wd = 8'h00;
    logic [31:0] log_addr[$];
    logic        log_we[$];
    logic [7:0]  log_wd[$];
    logic [7:0]  mem_img[logic [31:0]];

    lsu_byte_initiator #(.MAX_WAIT(MW)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return 8'((a * 32'h9E3779B1) >> 13);
    endfunction

    function automatic int model_beats(input logic [2:0] sz);
        if (sz == LW_SW) return 4;
        if (sz == LH_SH || sz == LHU) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] sz, input logic [31:0] a);
        logic [31:0] w;
        w = 32'h0;
        for (int i = 0; i < model_beats(sz); i++) begin
            w = w | (32'(rd_byte(a + 32'(i))) << (8 * i));
        end
        if (sz == LBU) return w & 32'h0000_00FF;
        if (sz == LHU) return w & 32'h0000_FFFF;
        if (sz == LH_SH) return {{16{w[15]}}, w[15:0]};
        if (sz == LW_SW) return w;
        return {{24{w[7]}}, w[7:0]};
    endfunction

    // Memory responder: drives gnt/rvalid on the falling edge, logs every granted beat.
    always @(negedge clock) begin
        if (reset) begin
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            pending = 1'b0;
            stall_cnt = 0;
        end else begin
            mem_rvalid = 1'b0;
            if (stray_rvalid) begin
                mem_rvalid = 1'b1;
                mem_rdata = 8'h5A;
            end
            if (!rv_enable) pending = 1'b0;
            if (pending) begin
                if (rv_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = rd_byte(pend_addr);
                    pending = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end
            mem_gnt = 1'b0;
            if (mem_req) begin
                if (stall_cnt > 0) begin
                    check_eq("stall_addr", mem_addr, held_addr);
                    check_eq("stall_wdata", 32'(mem_wdata), 32'(held_wd));
                end
                held_addr = mem_addr;
                held_wd = mem_wdata;
                if (stall_cnt < gnt_stall) begin
                    stall_cnt++;
                end else begin
                    mem_gnt = 1'b1;
                    stall_cnt = 0;
                    log_addr.push_back(mem_addr);
                    log_we.push_back(mem_we);
                    log_wd.push_back(mem_wdata);
                    if (!mem_we) begin
                        pending = 1'b1;
                        pend_addr = mem_addr;
                        rv_cnt = rv_delay;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic do_txn(input logic we, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input int st, input int rd, input bit tmo);
        int t;
        int n;
        int lat;
        int nb;
        logic [31:0] exp_data;
        bit got;
        gnt_stall = st;
        rv_delay = rd;
        rv_enable = !tmo;
        log_addr.delete();
        log_we.delete();
        log_wd.delete();
        check_eq("ready_before", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we = we;
        req_size = sz;
        req_addr = a;
        req_wdata = wd;
        t = cyc;
        step();
        req_valid = 1'b0;
        req_we = 1'($urandom);
        req_size = 3'($urandom);
        req_addr = $urandom;
        req_wdata = $urandom;
        n = model_beats(sz);
        if (tmo) begin
            nb = 1;
            lat = (st + 1) + MW + 1;
            exp_data = 32'h0;
        end else begin
            nb = n;
            lat = we ? n * (st + 1) + 1 : n * (st + rd + 2) + 1;
            exp_data = we ? 32'h0 : model_load(sz, a);
        end
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            if (resp_valid) got = 1'b1;
            else step();
        end
        check_eq("resp_seen", 32'(resp_valid), 32'd1);
        if (got) begin
            check_eq("latency", 32'(cyc - t), 32'(lat));
            check_eq("rdata", resp_rdata, exp_data);
            check_eq("err", 32'(resp_err), 32'(tmo));
            check_eq("beat_count", 32'(log_addr.size()), 32'(nb));
            for (int i = 0; i < nb && i < log_addr.size(); i++) begin
                check_eq("beat_addr", log_addr[i], a + 32'(i));
                check_eq("beat_we", 32'(log_we[i]), 32'(we));
                if (we) check_eq("beat_wdata", 32'(log_wd[i]), 32'(8'(wd >> (8 * i))));
            end
            step();
            check_eq("resp_pulse", 32'(resp_valid), 32'd0);
            check_eq("ready_after", 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        bit seen;
        logic [31:0] wd;
        step();
        step();
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        check_eq("rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("rst_resp", 32'(resp_valid), 32'd0);
        check_eq("rst_addr", mem_addr, 32'h0);
        check_eq("rst_rdata", resp_rdata, 32'h0);
        reset = 1'b0;
        step();

        mem_img[32'h21] = 8'h80;
        mem_img[32'h22] = 8'hFF;
        mem_img[32'h40] = 8'h9C;

        do_txn(1'b1, LW_SW, 32'h10, 32'hA1B2C3D4, 0, 0, 1'b0);
        do_txn(1'b0, LH_SH, 32'h21, 32'h0, 0, 0, 1'b0);
        do_txn(1'b0, LHU, 32'h21, 32'h0, 0, 0, 1'b0);
        do_txn(1'b0, LB_SB, 32'h40, 32'h0, 0, 0, 1'b0);
        do_txn(1'b0, LBU, 32'h40, 32'h0, 0, 0, 1'b0);
        do_txn(1'b0, 3'b011, 32'h40, 32'h0, 0, 0, 1'b0);
        do_txn(1'b0, LW_SW, 32'hFFFFFFFE, 32'h0, 3, 0, 1'b0);
        do_txn(1'b1, LHU, 32'hFFFFFFFF, 32'h1234ABCD, 1, 0, 1'b0);

        // rvalid withheld: timeout, then a late rvalid must not disturb IDLE
        do_txn(1'b0, LB_SB, 32'h55, 32'h0, 0, 0, 1'b1);
        stray_rvalid = 1'b1;
        step();
        stray_rvalid = 1'b0;
        check_eq("stray_ready", 32'(req_ready), 32'd1);
        check_eq("stray_resp", 32'(resp_valid), 32'd0);
        step();
        check_eq("stray_resp2", 32'(resp_valid), 32'd0);
        rv_enable = 1'b1;

        // reset during beat 2 of a word store
        gnt_stall = 0;
        req_valid = 1'b1;
        req_we = 1'b1;
        req_size = LW_SW;
        req_addr = 32'h100;
        req_wdata = 32'hCAFEF00D;
        step();
        req_valid = 1'b0;
        step();
        step();
        check_eq("mid_beat_addr", mem_addr, 32'h102);
        reset = 1'b1;
        step();
        check_eq("mid_rst_ready", 32'(req_ready), 32'd1);
        check_eq("mid_rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("mid_rst_resp", 32'(resp_valid), 32'd0);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (resp_valid) seen = 1'b1;
        end
        check_eq("no_resp_after_rst", 32'(seen), 32'd0);
        do_txn(1'b0, LB_SB, 32'h40, 32'h0, 0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            wd = $urandom;
            do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : $urandom,
                   wd, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
